// File: rtl/clk_period_monitor.sv
// ---------------------------------------------------------------------------
// ClkPeriodMonitor (module clk_period_monitor)
//
// Purpose:
//   Receiving end of a clock/pulse generator. Measures the period of an
//   asynchronous periodic input (SigIn) in units of Clk cycles, compares each
//   measured period against an expected value with a tolerance, counts the
//   out-of-tolerance periods, reports a lock after a run of good periods and
//   flags an input that has stopped toggling.
//
// Parameters:
//   CNT_W        width of the period counter and of Period
//   EXPECT       expected period in Clk cycles (must be < 2**CNT_W-1)
//   TOL          allowed |Period-EXPECT| in Clk cycles
//   SYNC_STAGES  synchroniser depth for SigIn (>= 2)
//   MIN_GOOD     consecutive good periods needed for Locked (1..15)
//
// Ports:
//   Clk          in   system clock, all logic on the rising edge
//   Reset        in   asynchronous active-high reset
//   Enable       in   1 = measure, 0 = disarm (results hold)
//   SigIn        in   asynchronous signal under test
//   Period       out  last measured period in Clk cycles
//   PeriodValid  out  one-cycle pulse whenever Period is updated
//   ErrPulse     out  one-cycle pulse with PeriodValid for a bad period
//   ErrCount     out  number of bad periods, saturating at 255
//   Locked       out  MIN_GOOD consecutive good periods seen
//   Stuck        out  no SigIn edge for 2**CNT_W-1 cycles
//   HighTime     out  (only with MON_DUTY_EN) synced-high cycles within
//                     the last reported period, latched with Period
//
// Configuration:
//   MON_DUTY_EN  when defined, adds the HighTime output and its counter.
// ---------------------------------------------------------------------------
module clk_period_monitor #(
    parameter int CNT_W       = 16,
    parameter int EXPECT      = 8,
    parameter int TOL         = 1,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_GOOD    = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             SigIn,
    output logic [CNT_W-1:0] Period,
    output logic             PeriodValid,
    output logic             ErrPulse,
    output logic [7:0]       ErrCount,
    output logic             Locked,
    output logic             Stuck
`ifdef MON_DUTY_EN
    ,
    output logic [CNT_W-1:0] HighTime
`endif
);

    // Counter saturation value doubles as the stuck-input timeout.
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] EXPECT_C   = CNT_W'(EXPECT);
    localparam logic [CNT_W-1:0] TOL_C      = CNT_W'(TOL);
    localparam logic [3:0]       MIN_GOOD_C = 4'(MIN_GOOD);
    localparam logic [7:0]       ERR_MAX    = 8'hFF;

    typedef enum logic {
        ARM,
        COUNT
    } stateType;

    stateType             state;
    logic [CNT_W-1:0]     cnt;
    logic [3:0]           run;
    logic [SYNC_STAGES-1:0] syncReg;
    logic                 syncD;
    logic                 sigSync;
    logic                 edgeDet;
    logic [CNT_W-1:0]     periodDiff;
    logic                 periodGood;
    logic [3:0]           runInc;
    logic                 armEdge;
    logic                 reportEdge;
    logic                 timeoutNow;

    // SigIn is asynchronous, so it first crosses a plain flop chain. One
    // extra flop behind the chain gives the previous synced value so that a
    // rising edge can be detected without looking at the raw input.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            syncReg <= '0;
            syncD   <= 1'b0;
        end else begin
            syncReg <= {syncReg[SYNC_STAGES-2:0], SigIn};
            syncD   <= syncReg[SYNC_STAGES-1];
        end
    end

    // Edge detect plus the three events the FSM reacts to. Enable gates all
    // of them, so a disarmed monitor ignores an edge arriving in the same
    // cycle. The timeout only fires when no edge is present, so an edge
    // landing exactly on the last count still reports a period.
    always_comb begin
        sigSync    = syncReg[SYNC_STAGES-1];
        edgeDet    = sigSync & ~syncD;
        armEdge    = Enable && (state == ARM) && edgeDet;
        reportEdge = Enable && (state == COUNT) && edgeDet;
        timeoutNow = Enable && (state == COUNT) && !edgeDet && (cnt == CNT_MAX);
    end

    // Tolerance check on the value about to be reported. The distance is
    // taken as larger-minus-smaller so that nothing wraps around, and the
    // run length saturates at MIN_GOOD so Locked stays set on a long run.
    always_comb begin
        if (cnt >= EXPECT_C) begin
            periodDiff = cnt - EXPECT_C;
        end else begin
            periodDiff = EXPECT_C - cnt;
        end
        periodGood = (periodDiff <= TOL_C);
        if (run >= MIN_GOOD_C) begin
            runInc = MIN_GOOD_C;
        end else begin
            runInc = run + 4'd1;
        end
    end

    // Main measurement FSM with all status outputs registered. ARM waits for
    // a first edge so that a partial period is never reported; COUNT counts
    // cycles since the last edge. The counter restarts at 1 on every edge so
    // that an N-cycle input reports exactly N. Pulse outputs default low
    // every cycle, which keeps them one cycle wide.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= ARM;
            cnt         <= '0;
            run         <= '0;
            Period      <= '0;
            PeriodValid <= 1'b0;
            ErrPulse    <= 1'b0;
            ErrCount    <= '0;
            Locked      <= 1'b0;
            Stuck       <= 1'b0;
        end else begin
            PeriodValid <= 1'b0;
            ErrPulse    <= 1'b0;
            if (!Enable) begin
                state  <= ARM;
                cnt    <= '0;
                run    <= '0;
                Locked <= 1'b0;
            end else begin
                case (state)
                    ARM: begin
                        if (armEdge) begin
                            state <= COUNT;
                            cnt   <= CNT_W'(1);
                            Stuck <= 1'b0;
                        end
                    end
                    COUNT: begin
                        if (reportEdge) begin
                            Period      <= cnt;
                            PeriodValid <= 1'b1;
                            cnt         <= CNT_W'(1);
                            if (periodGood) begin
                                run <= runInc;
                                if (runInc == MIN_GOOD_C) begin
                                    Locked <= 1'b1;
                                end
                            end else begin
                                ErrPulse <= 1'b1;
                                run      <= '0;
                                Locked   <= 1'b0;
                                if (ErrCount != ERR_MAX) begin
                                    ErrCount <= ErrCount + 8'd1;
                                end
                            end
                        end else if (timeoutNow) begin
                            // Input has gone quiet: drop back to ARM so the
                            // next edge only re-arms, and keep Period as is.
                            state  <= ARM;
                            cnt    <= '0;
                            run    <= '0;
                            Locked <= 1'b0;
                            Stuck  <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= ARM;
                    end
                endcase
            end
        end
    end

`ifdef MON_DUTY_EN
    logic [CNT_W-1:0] highCnt;

    // Duty measurement: counts synced-high cycles in the period being timed
    // and latches the count next to Period. It restarts at 1 on each edge
    // because the synced input is high in the edge cycle itself, which keeps
    // it aligned with the period counter. Disarm and timeout clear the
    // running count but leave the last reported HighTime in place.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            highCnt  <= '0;
            HighTime <= '0;
        end else if (!Enable) begin
            highCnt <= '0;
        end else if (armEdge || reportEdge) begin
            highCnt <= CNT_W'(1);
            if (reportEdge) begin
                HighTime <= highCnt;
            end
        end else if (timeoutNow) begin
            highCnt <= '0;
        end else if ((state == COUNT) && sigSync && (highCnt != CNT_MAX)) begin
            highCnt <= highCnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_clk_period_monitor.sv
// ---------------------------------------------------------------------------
// tb_clk_period_monitor
//
// Directed bench for clk_period_monitor built with CNT_W=6 so the stuck
// timeout (63 cycles) is short. SigIn is driven one Clk cycle at a time from
// a single initial block; outputs are observed on the falling edge. A small
// observer inside the step task counts PeriodValid pulses, error pulses and
// any pulse-shape violations, and the directed steps compare those tallies
// and the live outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_clk_period_monitor;

    localparam int CNT_W = 6;

    logic             Clk;
    logic             Reset;
    logic             Enable;
    logic             SigIn;
    logic [CNT_W-1:0] Period;
    logic             PeriodValid;
    logic             ErrPulse;
    logic [7:0]       ErrCount;
    logic             Locked;
    logic             Stuck;
`ifdef MON_DUTY_EN
    logic [CNT_W-1:0] HighTime;
`endif

    int compared   = 0;
    int mismatched = 0;
    int pvCount    = 0;
    int errSeen    = 0;
    int backToBack = 0;
    int orphanErr  = 0;
    logic prevPv   = 1'b0;

    clk_period_monitor #(
        .CNT_W       (CNT_W),
        .EXPECT      (8),
        .TOL         (1),
        .SYNC_STAGES (2),
        .MIN_GOOD    (4)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Enable      (Enable),
        .SigIn       (SigIn),
        .Period      (Period),
        .PeriodValid (PeriodValid),
        .ErrPulse    (ErrPulse),
        .ErrCount    (ErrCount),
        .Locked      (Locked),
        .Stuck       (Stuck)
`ifdef MON_DUTY_EN
        ,
        .HighTime    (HighTime)
`endif
    );

    // 10-time-unit clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // One comparison: counts it, and on a miss counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive SigIn for one Clk cycle, then observe outputs at the falling edge.
    task automatic stepCycle(input logic s);
        SigIn = s;
        @(negedge Clk);
        if (PeriodValid === 1'b1) begin
            pvCount++;
            if (ErrPulse === 1'b1) errSeen++;
            if (prevPv) backToBack++;
        end
        if (ErrPulse === 1'b1 && PeriodValid !== 1'b1) orphanErr++;
        prevPv = (PeriodValid === 1'b1);
    endtask

    // Drive count periods of a square wave, high cycles first.
    task automatic applyStimulus(input int high, input int low, input int count);
        for (int p = 0; p < count; p++) begin
            for (int h = 0; h < high; h++) stepCycle(1'b1);
            for (int l = 0; l < low; l++) stepCycle(1'b0);
        end
    endtask

    initial begin
        Reset  = 1'b1;
        Enable = 1'b0;
        SigIn  = 1'b0;
        repeat (3) stepCycle(1'b0);

        // Reset state
        checkOutput("rst_period", 32'(Period), 0);
        checkOutput("rst_pv", 32'(PeriodValid), 0);
        checkOutput("rst_err", 32'(ErrPulse), 0);
        checkOutput("rst_errcnt", 32'(ErrCount), 0);
        checkOutput("rst_locked", 32'(Locked), 0);
        checkOutput("rst_stuck", 32'(Stuck), 0);

        Reset  = 1'b0;
        Enable = 1'b1;

        // 4 high / 4 low: first edge only arms, Locked on the 4th report
        $display("[TB] nominal period 8");
        applyStimulus(4, 4, 1);
        checkOutput("t1_no_report_first_edge", 32'(pvCount), 0);
        applyStimulus(4, 4, 2);
        checkOutput("t1_two_reports", 32'(pvCount), 2);
        checkOutput("t1_period8", 32'(Period), 8);
        applyStimulus(4, 4, 1);
        checkOutput("t1_three_reports", 32'(pvCount), 3);
        checkOutput("t1_not_locked_at_3", 32'(Locked), 0);
        applyStimulus(4, 4, 1);
        checkOutput("t1_four_reports", 32'(pvCount), 4);
        checkOutput("t1_locked_at_4", 32'(Locked), 1);
        checkOutput("t1_errcnt0", 32'(ErrCount), 0);

        // Period 10 is out of tolerance; the first report is still the 8 gap
        $display("[TB] out-of-tolerance period 10 then period 9");
        applyStimulus(5, 5, 3);
        checkOutput("t2_reports", 32'(pvCount), 7);
        checkOutput("t2_errpulses", 32'(errSeen), 2);
        checkOutput("t2_errcnt", 32'(ErrCount), 2);
        checkOutput("t2_unlocked", 32'(Locked), 0);
        checkOutput("t2_period10", 32'(Period), 10);
        applyStimulus(4, 5, 5);
        checkOutput("t2b_reports", 32'(pvCount), 12);
        checkOutput("t2b_errcnt", 32'(ErrCount), 3);
        checkOutput("t2b_errpulses", 32'(errSeen), 3);
        checkOutput("t2b_locked", 32'(Locked), 1);
        checkOutput("t2b_period9", 32'(Period), 9);

        // Held low: Stuck exactly 63 cycles after the last detected edge
        $display("[TB] stuck input timeout");
        repeat (56) stepCycle(1'b0);
        checkOutput("t3_not_stuck_yet", 32'(Stuck), 0);
        checkOutput("t3_still_locked", 32'(Locked), 1);
        stepCycle(1'b0);
        checkOutput("t3_stuck", 32'(Stuck), 1);
        checkOutput("t3_unlocked", 32'(Locked), 0);
        checkOutput("t3_period_holds", 32'(Period), 9);
        checkOutput("t3_no_report", 32'(pvCount), 12);
        applyStimulus(4, 4, 1);
        checkOutput("t3_stuck_cleared", 32'(Stuck), 0);
        checkOutput("t3_rearm_no_report", 32'(pvCount), 12);
        applyStimulus(4, 4, 1);
        checkOutput("t3_restart_report", 32'(pvCount), 13);
        checkOutput("t3_restart_period", 32'(Period), 8);

        // Asynchronous reset while locked
        $display("[TB] reset mid-count");
        applyStimulus(4, 4, 3);
        checkOutput("t4_relocked", 32'(Locked), 1);
        checkOutput("t4_reports", 32'(pvCount), 16);
        Reset = 1'b1;
        #1;
        checkOutput("t4_async_period", 32'(Period), 0);
        checkOutput("t4_async_errcnt", 32'(ErrCount), 0);
        checkOutput("t4_async_locked", 32'(Locked), 0);
        checkOutput("t4_async_stuck", 32'(Stuck), 0);
        checkOutput("t4_async_pv", 32'(PeriodValid), 0);
        stepCycle(1'b0);
        stepCycle(1'b0);
        Reset = 1'b0;
        applyStimulus(4, 4, 1);
        checkOutput("t4_no_report_after_rst", 32'(pvCount), 16);
        applyStimulus(4, 4, 4);
        checkOutput("t4_reports_after_rst", 32'(pvCount), 20);
        checkOutput("t4_locked_after_rst", 32'(Locked), 1);
        checkOutput("t4_period_after_rst", 32'(Period), 8);

        // Disarm for 20 cycles while SigIn keeps toggling
        $display("[TB] enable low mid-stream");
        Enable = 1'b0;
        applyStimulus(4, 4, 2);
        repeat (4) stepCycle(1'b1);
        checkOutput("t5_no_report_disabled", 32'(pvCount), 20);
        checkOutput("t5_unlocked_disabled", 32'(Locked), 0);
        checkOutput("t5_period_holds", 32'(Period), 8);
        Enable = 1'b1;
        repeat (4) stepCycle(1'b0);
        applyStimulus(4, 4, 1);
        checkOutput("t5_rearm_no_report", 32'(pvCount), 20);
        applyStimulus(4, 4, 1);
        checkOutput("t5_report_2nd_edge", 32'(pvCount), 21);
        checkOutput("t5_period8", 32'(Period), 8);

        // ErrCount saturation: 254, then 255, then stays at 255
        $display("[TB] error counter saturation");
        applyStimulus(5, 5, 255);
        checkOutput("t5_errcnt254", 32'(ErrCount), 254);
        checkOutput("t5_reports_sat", 32'(pvCount), 276);
        applyStimulus(5, 5, 1);
        checkOutput("t5_errcnt255", 32'(ErrCount), 255);
        applyStimulus(5, 5, 2);
        checkOutput("t5_errcnt_sticks", 32'(ErrCount), 255);
        checkOutput("t5_errpulses_total", 32'(errSeen), 260);
        checkOutput("t5_reports_total", 32'(pvCount), 279);

`ifdef MON_DUTY_EN
        // 3 high / 5 low: HighTime latched with each period
        $display("[TB] duty measurement");
        applyStimulus(3, 5, 3);
        checkOutput("t6_reports", 32'(pvCount), 282);
        checkOutput("t6_period8", 32'(Period), 8);
        checkOutput("t6_hightime3", 32'(HighTime), 3);
`endif

        // Pulse shape over the whole run
        checkOutput("pv_never_back_to_back", 32'(backToBack), 0);
        checkOutput("errpulse_only_with_pv", 32'(orphanErr), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
